// File: rtl/usb_kbd_events.sv
// Turns successive boot-protocol HID keyboard reports into make/break events queued in a FIFO.
// Define USB_KBD_TYPEMATIC_EN to add auto-repeat of the most recently pressed key.
module usb_kbd_events #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned REPEAT_DELAY = 12_500_000,
    parameter int unsigned REPEAT_RATE  = 2_500_000
) (
    input  logic                        clk,
    input  logic                        reset_n_i,
    input  logic [63:0]                 usb_report_i,
    input  logic                        usb_report_valid_i,
    output logic [9:0]                  event_o,
    output logic                        event_valid_o,
    input  logic                        event_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic [7:0]                  modifiers_o,
    output logic                        overflow_o,
    input  logic                        clear_i
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_MOD, S_REL, S_PRS, S_COMMIT} state_t;

    // Stored report layout: [55:8] key slots 0..5, [7:0] modifiers; the reserved byte is dropped.
    logic [55:0] rpt_in;
    logic        rollover;
    logic        unused_reserved;

    assign rpt_in          = {usb_report_i[63:16], usb_report_i[7:0]};
    assign rollover        = (usb_report_i[63:16] == {6{8'h01}});
    assign unused_reserved = ^usb_report_i[15:8];

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [55:0] old_q, old_d;
    logic [55:0] new_q, new_d;
    logic [55:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    head;

    logic       push;
    logic [9:0] push_data;
    logic       pop;
    logic       full;
    logic       wr_en;

`ifdef USB_KBD_TYPEMATIC_EN
    logic [7:0]  rpt_key_q, rpt_key_d;
    logic        rpt_vld_q, rpt_vld_d;
    logic [31:0] rpt_tmr_q, rpt_tmr_d;
    logic        rpt_in_new;
`endif

    // Slots 6 and 7 are padding so a 3-bit index never leaves the array.
    logic [7:0] old_keys [8];
    logic [7:0] new_keys [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_keys
            if (gi < 6) begin : g_slot
                assign old_keys[gi] = old_q[8 + 8*gi +: 8];
                assign new_keys[gi] = new_q[8 + 8*gi +: 8];
            end else begin : g_pad
                assign old_keys[gi] = 8'h00;
                assign new_keys[gi] = 8'h00;
            end
        end
    endgenerate

    logic [7:0] cur_old;
    logic [7:0] cur_new;
    logic       old_in_new;
    logic       new_in_old;

    assign cur_old = old_keys[idx_q];
    assign cur_new = new_keys[idx_q];

    always_comb begin
        old_in_new = 1'b0;
        new_in_old = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (new_keys[j] == cur_old) old_in_new = 1'b1;
            if (old_keys[j] == cur_new) new_in_old = 1'b1;
        end
    end

`ifdef USB_KBD_TYPEMATIC_EN
    always_comb begin
        rpt_in_new = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (new_keys[j] == rpt_key_q) rpt_in_new = 1'b1;
        end
    end
`endif

    // Scan sequencer: fixed 21-cycle walk over modifiers, released keys, pressed keys, commit.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        old_d      = old_q;
        new_d      = new_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        push       = 1'b0;
        push_data  = 10'h000;
`ifdef USB_KBD_TYPEMATIC_EN
        rpt_key_d  = rpt_key_q;
        rpt_vld_d  = rpt_vld_q;
        rpt_tmr_d  = rpt_tmr_q;
        if (rpt_vld_q && (rpt_tmr_q > 32'd1)) begin
            rpt_tmr_d = rpt_tmr_q - 32'd1;
        end
`endif

        if ((state_q != S_IDLE) && usb_report_valid_i && !rollover) begin
            pend_d     = rpt_in;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (usb_report_valid_i && !rollover) begin
                    new_d   = rpt_in;
                    idx_d   = 3'd0;
                    state_d = S_MOD;
                end
`ifdef USB_KBD_TYPEMATIC_EN
                // An expired timer waits here so repeats never collide with scan pushes.
                if (rpt_vld_q && (rpt_tmr_q <= 32'd1)) begin
                    push      = 1'b1;
                    push_data = {2'b11, rpt_key_q};
                    rpt_tmr_d = REPEAT_RATE;
                end
`endif
            end
            S_MOD: begin
                if (old_q[idx_q] != new_q[idx_q]) begin
                    push      = 1'b1;
                    push_data = {1'b0, new_q[idx_q], 5'b11100, idx_q};
                end
                if (idx_q == 3'd7) begin
                    idx_d   = 3'd0;
                    state_d = S_REL;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_REL: begin
                if ((cur_old != 8'h00) && !old_in_new) begin
                    push      = 1'b1;
                    push_data = {2'b00, cur_old};
                end
                if (idx_q == 3'd5) begin
                    idx_d   = 3'd0;
                    state_d = S_PRS;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_PRS: begin
                if ((cur_new != 8'h00) && !new_in_old) begin
                    push      = 1'b1;
                    push_data = {2'b01, cur_new};
`ifdef USB_KBD_TYPEMATIC_EN
                    rpt_key_d = cur_new;
                    rpt_vld_d = 1'b1;
                    rpt_tmr_d = REPEAT_DELAY;
`endif
                end
                if (idx_q == 3'd5) begin
                    idx_d   = 3'd0;
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_COMMIT: begin
                old_d = new_q;
                idx_d = 3'd0;
                // A strobe landing on this very cycle is newer than anything pending.
                if (usb_report_valid_i && !rollover) begin
                    new_d      = rpt_in;
                    pend_vld_d = 1'b0;
                    state_d    = S_MOD;
                end else if (pend_vld_q) begin
                    new_d      = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = S_MOD;
                end else begin
                    state_d = S_IDLE;
                end
`ifdef USB_KBD_TYPEMATIC_EN
                if (rpt_vld_q && !rpt_in_new) begin
                    rpt_vld_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    always_comb begin
        pop      = (cnt_q != '0) && event_ready_i;
        full     = (cnt_q == DEPTH_C);
        wr_en    = push && (!full || pop);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (clear_i) ovf_d = 1'b0;
        if (push && !wr_en) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            old_q      <= '0;
            new_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef USB_KBD_TYPEMATIC_EN
            rpt_key_q  <= 8'h00;
            rpt_vld_q  <= 1'b0;
            rpt_tmr_q  <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            old_q      <= old_d;
            new_q      <= new_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
`ifdef USB_KBD_TYPEMATIC_EN
            rpt_key_q  <= rpt_key_d;
            rpt_vld_q  <= rpt_vld_d;
            rpt_tmr_q  <= rpt_tmr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign event_valid_o = (cnt_q != '0);
    assign count_o       = cnt_q;
    assign modifiers_o   = old_q[7:0];
    assign overflow_o    = ovf_q;

`ifdef USB_KBD_TYPEMATIC_EN
    assign event_o = event_valid_o ? head : 10'h000;
`else
    logic unused_head_rpt;
    logic unused_params;

    assign event_o         = event_valid_o ? {1'b0, head[8:0]} : 10'h000;
    assign unused_head_rpt = head[9];
    assign unused_params   = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

endmodule

// File: tb/tb_usb_kbd_events.sv
// Directed plus randomized check of usb_kbd_events against a report-diff reference model.
module tb_usb_kbd_events;
    logic        clk = 1'b0;
    logic        reset_n_i;
    logic [63:0] usb_report_i;
    logic        usb_report_valid_i;
    logic [9:0]  event_o;
    logic        event_valid_o;
    logic        event_ready_i;
    logic [2:0]  count_o;
    logic [7:0]  modifiers_o;
    logic        overflow_o;
    logic        clear_i;

    always #5 clk = ~clk;

    usb_kbd_events #(
        .FIFO_DEPTH  (4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5)
    ) dut (
        .clk               (clk),
        .reset_n_i         (reset_n_i),
        .usb_report_i      (usb_report_i),
        .usb_report_valid_i(usb_report_valid_i),
        .event_o           (event_o),
        .event_valid_o     (event_valid_o),
        .event_ready_i     (event_ready_i),
        .count_o           (count_o),
        .modifiers_o       (modifiers_o),
        .overflow_o        (overflow_o),
        .clear_i           (clear_i)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [9:0]  obs_q[$];
    int          obs_cyc[$];
    logic [9:0]  rpt_q[$];
    int          rpt_cyc[$];
    logic [9:0]  exp_q[$];
    logic [63:0] model_old;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every popped event; auto-repeat events go to their own queue.
    always @(negedge clk) begin
        if (reset_n_i && event_valid_o && event_ready_i) begin
            if (event_o[9]) begin
                rpt_q.push_back(event_o);
                rpt_cyc.push_back(cyc);
            end else begin
                obs_q.push_back(event_o);
                obs_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] r);
        usb_report_i       = r;
        usb_report_valid_i = 1'b1;
        step(1);
        usb_report_valid_i = 1'b0;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] m, input logic [7:0] k0, input logic [7:0] k1,
                                       input logic [7:0] k2, input logic [7:0] k3, input logic [7:0] k4,
                                       input logic [7:0] k5);
        return {k5, k4, k3, k2, k1, k0, 8'h00, m};
    endfunction

    function automatic logic has_key(input logic [63:0] r, input logic [7:0] k);
        for (int i = 0; i < 6; i++) begin
            if (r[16 + 8*i +: 8] == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected events for moving from the committed report to r, in emission order.
    function automatic void model_scan(input logic [63:0] r);
        logic [7:0] ko;
        logic [7:0] kn;
        logic [9:0] ev;
        if (r[63:16] == 48'h010101010101) return;
        for (int k = 0; k < 8; k++) begin
            if (model_old[k] != r[k]) begin
                ev = 10'h0E0 + 10'(k);
                if (r[k]) ev = ev + 10'h100;
                exp_q.push_back(ev);
            end
        end
        for (int i = 0; i < 6; i++) begin
            ko = model_old[16 + 8*i +: 8];
            if (ko != 8'h00 && !has_key(r, ko)) exp_q.push_back({2'b00, ko});
        end
        for (int i = 0; i < 6; i++) begin
            kn = r[16 + 8*i +: 8];
            if (kn != 8'h00 && !has_key(model_old, kn)) exp_q.push_back({2'b01, kn});
        end
        model_old = r;
    endfunction

    task automatic check_events(input string tag);
        chk({tag, "_num"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            chk(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] r;
        logic [7:0]  pool [6];
        int          t0;
        pool = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};

        reset_n_i          = 1'b0;
        usb_report_i       = '0;
        usb_report_valid_i = 1'b0;
        event_ready_i      = 1'b0;
        clear_i            = 1'b0;
        model_old          = '0;
        step(3);
        reset_n_i = 1'b1;
        step(1);
        chk("rst_valid", event_valid_o, 0);
        chk("rst_event", event_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_mods", modifiers_o, 0);
        chk("rst_ovf", overflow_o, 0);

        // First press: single event, pushed in the first PRS cycle.
        r = mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(14);
        chk("lat_cnt14", count_o, 0);
        step(1);
        chk("lat_cnt15", count_o, 1);
        chk("lat_head", event_o, 10'h104);
        step(7);
        chk("cnt22", count_o, 1);
        chk("mods_a", modifiers_o, 8'h00);

        // Modifier change plus key swap fills the 4-deep FIFO exactly.
        r = mk(8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(22);
        chk("seq_cnt", count_o, 4);
        chk("seq_ovf", overflow_o, 0);
        chk("seq_mods", modifiers_o, 8'h02);
        chk("seq_head", event_o, 10'h104);
        event_ready_i = 1'b1;
        step(6);
        check_events("seq");

        r = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(24);
        check_events("release");

        // Overflow: six presses into four entries.
        event_ready_i = 1'b0;
        r = mk(8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
        send(r);
        model_scan(r);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        step(22);
        chk("ovf_cnt", count_o, 4);
        chk("ovf_set", overflow_o, 1);
        chk("ovf_head", event_o, 10'h104);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        chk("ovf_clr", overflow_o, 0);
        chk("ovf_cnt2", count_o, 4);

        // Drops while clear_i is held: set wins, then clear takes effect once drops stop.
        clear_i = 1'b1;
        r = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        step(9);
        chk("setwin_ovf", overflow_o, 1);
        step(6);
        chk("setwin_clr", overflow_o, 0);
        clear_i = 1'b0;
        step(7);
        event_ready_i = 1'b1;
        step(6);
        check_events("ovf_drain");

        // Strobes 5 and 10 cycles into a scan: the middle report is superseded.
        begin
            logic [63:0] ra, rb, rc;
            ra = mk(8'h10, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
            rb = mk(8'h20, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
            rc = mk(8'h40, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
            send(ra);
            model_scan(ra);
            step(4);
            send(rb);
            step(4);
            send(rc);
            model_scan(rc);
            step(31);
            chk("pend_mods_a", modifiers_o, 8'h10);
            step(1);
            chk("pend_mods_c", modifiers_o, 8'h40);
            step(4);
            check_events("pending");
        end

        // Rollover-error report is ignored entirely.
        r = mk(8'h11, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(24);
        check_events("pre_ro");
        r = mk(8'h44, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        send(r);
        model_scan(r);
        step(24);
        chk("ro_mods", modifiers_o, 8'h11);
        check_events("ro");

        // Reset in the middle of a scan.
        send(mk(8'h22, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00));
        step(12);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", event_valid_o, 0);
        chk("mid_rst_event", event_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_mods", modifiers_o, 0);
        chk("mid_rst_ovf", overflow_o, 0);
        step(2);
        reset_n_i = 1'b1;
        step(1);
        obs_q.delete();
        obs_cyc.delete();
        rpt_q.delete();
        rpt_cyc.delete();
        exp_q.delete();
        model_old = '0;
        r = mk(8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(24);
        check_events("post_rst");

        // Randomized reports from a small key pool so overlaps and duplicates are common.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = mk(8'($urandom), 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
            end else begin
                r = mk(8'($urandom),
                       pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                       pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                       pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)]);
            end
            r[15:8] = 8'($urandom);
            send(r);
            model_scan(r);
            step(24);
            check_events("rand");
            chk("rand_mods", modifiers_o, model_old[7:0]);
        end

`ifdef USB_KBD_TYPEMATIC_EN
        r = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(60);
        check_events("tm_pre");
        rpt_q.delete();
        rpt_cyc.delete();
        r = mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(46);
        t0 = (obs_cyc.size() > 0) ? obs_cyc[0] : -1000;
        r = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(r);
        model_scan(r);
        step(60);
        chk("tm_count", rpt_q.size(), 3);
        for (int i = 0; i < rpt_q.size(); i++) begin
            chk("tm_value", rpt_q[i], 10'h304);
            chk("tm_time", rpt_cyc[i] - t0, 20 + 5*i);
        end
        check_events("tm");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
